// File: rtl/stream_mux_pkg.sv
// Shared encodings for the N-to-1 stream multiplexer.
// This package holds the FSM states and the mode input codes.
package stream_mux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search.
// It returns the first requesting channel found after ptr, wrapping modulo N_IN.
module rr_pick #(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_valid
);

  int pos;

  // ptr is always below N_IN, so ptr+k stays under 2*N_IN and one subtraction wraps it.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    pos       = 0;
    for (int k = 1; k <= N_IN; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_IN) pos = pos - N_IN;
      for (int j = 0; j < N_IN; j++) begin
        if (!any_valid && req[j] && (j == pos)) begin
          any_valid = 1'b1;
          grant     = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// N-to-1 stream multiplexer with a registered output stage.
// It offers fixed or round-robin arbitration and holds each packet on its channel until the last beat.
module stream_mux_n_to_1 #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      select,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_last,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  import stream_mux_pkg::*;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;

  logic [SEL_W-1:0]   rr_grant;
  logic               rr_any;
  logic [SEL_W-1:0]   cand;
  logic               cand_ok;
  logic               can_load;
  logic               xfer;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_last;

  rr_pick #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .any_valid (rr_any)
  );

  assign can_load = !out_valid_q || out_ready;

  // While locked, mode and select are ignored; an out-of-range fixed select is never eligible.
  always_comb begin
    cand    = lock_ch_q;
    cand_ok = 1'b1;
    if (state_q == ST_IDLE) begin
      if (mode == MODE_RR) begin
        cand    = rr_grant;
        cand_ok = rr_any;
      end else begin
        cand    = select;
        cand_ok = (int'(select) < N_IN);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (cand == SEL_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = in_valid[i] && cand_ok && can_load && !reset;
      end
    end
  end

  assign xfer = |in_ready;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = cand;
      if (state_q == ST_IDLE) begin
        rr_ptr_d = cand;
        if (!sel_last) begin
          state_d   = ST_LOCKED;
          lock_ch_d = cand;
        end
      end else if (sel_last) begin
        state_d = ST_IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_IN - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// Self-checking bench for stream_mux_n_to_1: directed scenarios plus random traffic.
// A transaction-level model inside the bench predicts every result.
module tb_stream_mux_n_to_1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, mode, out_ready;
  logic [SW-1:0]   select;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid, out_last;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;

  logic            reset3, mode3, out_ready3;
  logic [1:0]      select3;
  logic [2:0]      in_valid3, in_last3, in_ready3;
  logic [23:0]     in_data3;
  logic            out_valid3, out_last3;
  logic [7:0]      out_data3;
  logic [1:0]      out_ch3;

  stream_mux_n_to_1 #(.N_IN(N), .WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_n_to_1 #(.N_IN(3), .WIDTH(8), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset3), .mode(mode3), .select(select3),
    .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  int checks = 0;
  int fails  = 0;

  // Model state: packet lock, round-robin pointer and the held output beat.
  bit         m_locked;
  int         m_lock_ch;
  int         m_rr;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_ol;
  int         m_och;
  logic [N-1:0] seen_ready;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_locked  = 0;
    m_lock_ch = 0;
    m_rr      = N - 1;
    m_ov      = 0;
    m_od      = '0;
    m_ol      = 0;
    m_och     = 0;
  endtask

  // Channel granted this cycle, or -1 when nothing transfers.
  function automatic int model_grant();
    int c;
    if (reset) return -1;
    if (m_ov && !out_ready) return -1;
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    if (mode == 1'b0) begin
      if (int'(select) < N && in_valid[select]) return int'(select);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_rr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (reset) begin
      model_reset();
    end else if (g >= 0) begin
      m_ov  = 1;
      m_od  = in_data[g*W +: W];
      m_ol  = in_last[g];
      m_och = g;
      if (!m_locked) begin
        m_rr      = g;
        m_locked  = !in_last[g];
        m_lock_ch = g;
      end else if (in_last[g]) begin
        m_locked = 0;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  // Drive one cycle of inputs, check against the model, then clock it.
  task automatic applyStimulus(input logic r, input logic md, input logic [1:0] sel,
                               input logic [3:0] v, input logic [31:0] d,
                               input logic [3:0] l, input logic ordy);
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    reset = r; mode = md; select = sel; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    seen_ready = in_ready;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
    checkOutput("out_data", 32'(out_data), 32'(m_od));
    checkOutput("out_last", 32'(out_last), 32'(m_ol));
    checkOutput("out_ch", 32'(out_ch), 32'(m_och));
    @(posedge clk);
    model_update(g);
  endtask

  initial begin
    int seq_ch[5];
    reset = 1; mode = 0; select = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    reset3 = 1; mode3 = 0; select3 = 0; in_valid3 = 0; in_data3 = 0; in_last3 = 0; out_ready3 = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

    // Out-of-range select on the three-channel instance grants nothing.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset3 = 0; mode3 = 0; select3 = 2'd3; in_valid3 = 3'b111;
      in_data3 = 24'($urandom); in_last3 = 3'($urandom); out_ready3 = 1'($urandom);
      #1;
      checkOutput("oor_in_ready", 32'(in_ready3), 32'd0);
      checkOutput("oor_out_valid", 32'(out_valid3), 32'd0);
    end

    applyStimulus(1, 0, 0, 4'hF, 32'h0, 4'h0, 1);

    // Fixed select on channel 2.
    applyStimulus(0, 0, 2, 4'b0100, 32'h00A5_0000, 4'hF, 1);
    checkOutput("fixed_ready", 32'(seen_ready), 32'h4);
    #1;
    checkOutput("fixed_valid", 32'(out_valid), 32'd1);
    checkOutput("fixed_data", 32'(out_data), 32'hA5);
    checkOutput("fixed_ch", 32'(out_ch), 32'd2);

    // Round-robin fairness from reset, including the 3 -> 0 wrap.
    applyStimulus(1, 1, 0, 4'h0, 32'h0, 4'h0, 1);
    seq_ch = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 4'hF, 32'h13121110, 4'hF, 1);
      #1;
      checkOutput("rr_ch", 32'(out_ch), 32'(seq_ch[k]));
    end

    // Packet lock on channel 1 while mode and select toggle.
    applyStimulus(0, 1, 0, 4'b0011, 32'h0000_B1A0, 4'b0001, 1);
    #1 checkOutput("lock_ch_b1", 32'(out_ch), 32'd1);
    applyStimulus(0, 0, 0, 4'b0011, 32'h0000_B2A0, 4'b0001, 1);
    #1 checkOutput("lock_ch_b2", 32'(out_ch), 32'd1);
    applyStimulus(0, 1, 3, 4'b0011, 32'h0000_B3A0, 4'b0011, 1);
    #1 checkOutput("lock_ch_b3", 32'(out_ch), 32'd1);
    applyStimulus(0, 1, 0, 4'b0001, 32'h0000_00A4, 4'b0001, 1);
    #1 checkOutput("lock_ch_after", 32'(out_ch), 32'd0);

    // Backpressure: hold for three cycles, then pop and reload together.
    applyStimulus(0, 0, 3, 4'b1000, 32'h3C00_0000, 4'hF, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 3, 4'b1000, 32'h7700_0000, 4'hF, 0);
      checkOutput("stall_ready", 32'(seen_ready), 32'd0);
      #1 checkOutput("stall_data", 32'(out_data), 32'h3C);
    end
    applyStimulus(0, 0, 3, 4'b1000, 32'h7700_0000, 4'hF, 1);
    checkOutput("release_ready", 32'(seen_ready), 32'h8);
    #1;
    checkOutput("release_valid", 32'(out_valid), 32'd1);
    checkOutput("release_data", 32'(out_data), 32'h77);

    // Reset while locked on channel 3.
    applyStimulus(0, 1, 0, 4'b1000, 32'h5100_0000, 4'h0, 1);
    applyStimulus(0, 1, 0, 4'b1000, 32'h5200_0000, 4'h0, 1);
    applyStimulus(1, 1, 0, 4'b1000, 32'h5300_0000, 4'h0, 1);
    #1 checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    applyStimulus(0, 1, 0, 4'hF, 32'h4433_2211, 4'h0, 1);
    checkOutput("midrst_ready", 32'(seen_ready), 32'h1);
    #1 checkOutput("midrst_ch", 32'(out_ch), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
                    4'($urandom), $urandom, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
